mgmt_gpio_ctrl: RTL
===================

Name: mgmt_gpio_ctrl

Overview:
Controller for the single management GPIO pad driven out of the management core. It gives firmware a Wishbone register interface for static output, output enable and a synchronised input. It also has a hardware blink sequencer that toggles the pad a programmed number of times, with no CPU involvement. It sits between the management Wishbone bus and the gpio pad signals, and raises an interrupt when a blink sequence completes.

Parameters:
PERIOD_W, 16, width of the half-period register in core_clk cycles
COUNT_W, 8, width of the blink-count register
SYNC_STAGES, 2, flops in the pad-input synchroniser (minimum 2)

Ports:
core_clk  input  1  system clock
core_rst  input  1  asynchronous, active-high reset
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_we_i  input  1  write enable
wb_adr_i  input  4  byte address; bits [3:2] select the register
wb_dat_i  input  32  write data
wb_sel_i  input  4  byte lanes; a write commits only if wb_sel_i[0]=1 (all fields live in byte 0/1, and byte 1 needs wb_sel_i[1])
wb_dat_o  output  32  read data
wb_ack_o  output  1  transfer acknowledge
gpio_out_pad  output  1  pad output value
gpio_oeb_pad  output  1  pad output-enable, active low
gpio_in_pad  input  1  asynchronous pad input
irq_o  output  1  level interrupt: done AND done_ie

Behaviour:
- Reset values: all registers 0; gpio_out_pad=0; gpio_oeb_pad=1; wb_ack_o=0; wb_dat_o=0; irq_o=0; FSM=IDLE; synchroniser flops=0.
- Bus handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o, so every access acks 1 cycle later, for exactly 1 cycle.
  - Writes commit on the edge that raises ack.
  - wb_dat_o is registered and valid while ack=1; it is 0 otherwise.
- Register map:
  - 0x0 CTRL: [0] out_val, [1] oe (gpio_oeb_pad = ~oe), [2] blink_en, [3] done_ie.
  - 0x4 PERIOD: [PERIOD_W-1:0] half-period P. P=0 is treated as 1.
  - 0x8 COUNT: [COUNT_W-1:0] number of blinks N. N=0 means blink until aborted.
  - 0xC STATUS:
    - [0] sync_in, read-only.
    - [1] busy (FSM != IDLE), read-only.
    - [2] done, sticky; writing 1 clears it.
    - [15:8] remaining, the blinks left, read-only.
- Input sync: sync_in is gpio_in_pad delayed through SYNC_STAGES flops. A pad edge is visible in STATUS exactly SYNC_STAGES cycles later.
- FSM states: IDLE, HIGH, LOW.
  - IDLE -> HIGH on the first edge where blink_en=1.
    - Loads phase counter = max(P,1) and remaining = N.
  - HIGH: gpio_out_pad=1. Decrements the phase counter each cycle. At count 1 -> LOW and reloads max(P,1).
  - LOW: gpio_out_pad=0. Decrements the phase counter each cycle. At count 1:
    - If N≠0 and remaining==1: -> IDLE, clear blink_en, set done.
    - Else: decrement remaining (unless N=0) and -> HIGH with reload.
  - The pad is therefore high for exactly P cycles, then low for exactly P cycles, per blink.
  - In IDLE, gpio_out_pad = out_val.
- Blink sequencer overrides only the output value. gpio_oeb_pad always follows CTRL.oe.
- Abort: a write of blink_en=0 while busy sends the FSM to IDLE on the next edge and sets no done. gpio_out_pad reverts to out_val on that same edge.
- PERIOD or COUNT written while busy: PERIOD takes effect at the next phase reload. COUNT takes effect only at the next IDLE->HIGH.
- Simultaneous events: if a done-set and a done W1C happen in the same cycle, set wins.
- Reset asserted mid-sequence returns every output to its reset value immediately (asynchronously).

Test Plan:
- Reset: assert core_rst mid-blink -> gpio_out_pad=0, gpio_oeb_pad=1, wb_ack_o=0 and busy=0 immediately. After release, reading 0xC gives 0x0000000X with bits [2:1]=0.
- Static output:
  - Write CTRL=0x3 -> gpio_oeb_pad=0 and gpio_out_pad=1 on the edge after the ack edge.
  - Write CTRL=0x2 -> gpio_out_pad=0.
  - Ack is exactly 1 cycle wide.
- Finite blink:
  - Setup: PERIOD=4, COUNT=3, CTRL=0x0E (blink_en, oe, done_ie).
  - Expect exactly 3 high pulses of 4 cycles each, separated by 4 low cycles.
  - Expect done=1, irq_o=1 and blink_en=0 afterwards.
  - W1C 0x4 to STATUS -> irq_o=0.
- Abort and infinite:
  - Setup: COUNT=0, PERIOD=0, blink_en=1 -> the pad toggles every cycle indefinitely.
  - Write CTRL=0x3 -> within 1 cycle the pad holds 1, busy=0 and done stays 0.
- Input sync: toggle gpio_in_pad -> STATUS[0] follows after exactly 2 cycles. A glitch narrower than 1 cycle between edges is not required to be seen.
- Live reprogram: during a PERIOD=8 blink, write PERIOD=2 -> the current phase completes at 8 cycles and subsequent phases are 2 cycles.

Source files
------------

// File: rtl/mgmt_gpio_ctrl.sv
// Management GPIO pad controller: Wishbone registers, 2-flop input sync and a blink sequencer.
// Pad outputs are registered: they follow register/FSM updates on the next core_clk edge.
module mgmt_gpio_ctrl #(
  parameter int PERIOD_W    = 16,
  parameter int COUNT_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        gpio_out_pad,
  output logic        gpio_oeb_pad,
  input  logic        gpio_in_pad,
  output logic        irq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic                   r_ack;
  logic [31:0]            r_dat;
  logic                   r_out_val;
  logic                   r_oe;
  logic                   r_blink_en;
  logic                   r_done_ie;
  logic                   r_done;
  logic [PERIOD_W-1:0]    r_period;
  logic [PERIOD_W-1:0]    r_phase;
  logic [COUNT_W-1:0]     r_count;
  logic [COUNT_W-1:0]     r_remaining;
  logic                   r_inf;
  logic [1:0]             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pad;
  logic                   r_oeb;

  logic [1:0]          w_state_nxt;
  logic                w_pad_nxt;
  logic                w_acc;
  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_wr_period;
  logic                w_wr_count;
  logic                w_wr_status;
  logic [15:0]         w_lane_mask;
  logic [PERIOD_W-1:0] w_reload;
  logic                w_phase_end;
  logic                w_last;
  logic                w_set_done;
  logic                w_sync_in;
  logic                w_busy;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_acc       = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr        = w_acc & wb_we_i & wb_sel_i[0];
  assign w_wr_ctrl   = w_wr & (wb_adr_i[3:2] == 2'd0);
  assign w_wr_period = w_wr & (wb_adr_i[3:2] == 2'd1);
  assign w_wr_count  = w_wr & (wb_adr_i[3:2] == 2'd2);
  assign w_wr_status = w_wr & (wb_adr_i[3:2] == 2'd3);
  assign w_lane_mask = {{8{wb_sel_i[1]}}, 8'hFF};
  assign w_unused    = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  assign w_reload    = (r_period == '0) ? PERIOD_W'(1) : r_period;
  assign w_phase_end = (r_phase == PERIOD_W'(1));
  assign w_last      = ~r_inf & (r_remaining == COUNT_W'(1));
  assign w_set_done  = (r_state == S_LOW) & r_blink_en & w_phase_end & w_last;
  assign w_sync_in   = r_sync[SYNC_STAGES-1];
  assign w_busy      = (r_state != S_IDLE);

  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;
  assign gpio_out_pad = r_pad;
  assign gpio_oeb_pad = r_oeb;
  assign irq_o        = r_done & r_done_ie;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state <= S_IDLE;
      r_pad   <= 1'b0;
      r_oeb   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pad   <= w_pad_nxt;
      r_oeb   <= ~r_oe;
    end
  end

  // Clearing blink_en (firmware abort) drops the sequencer to IDLE from either phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_blink_en) w_state_nxt = S_HIGH;
      S_HIGH: begin
        if (!r_blink_en)      w_state_nxt = S_IDLE;
        else if (w_phase_end) w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (!r_blink_en)      w_state_nxt = S_IDLE;
        else if (w_phase_end) w_state_nxt = w_last ? S_IDLE : S_HIGH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pad_nxt = r_out_val;
    case (w_state_nxt)
      S_HIGH:  w_pad_nxt = 1'b1;
      S_LOW:   w_pad_nxt = 1'b0;
      default: w_pad_nxt = r_out_val;
    endcase
  end

  // COUNT is latched only at sequence start; PERIOD is sampled at every phase reload.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_phase     <= '0;
      r_remaining <= '0;
      r_inf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_blink_en) begin
            r_phase     <= w_reload;
            r_remaining <= r_count;
            r_inf       <= (r_count == '0);
          end
        end
        S_HIGH: r_phase <= w_phase_end ? w_reload : r_phase - PERIOD_W'(1);
        S_LOW: begin
          if (w_phase_end) begin
            r_phase <= w_reload;
            if (w_last)      r_remaining <= '0;
            else if (!r_inf) r_remaining <= r_remaining - COUNT_W'(1);
          end else begin
            r_phase <= r_phase - PERIOD_W'(1);
          end
        end
        default: r_phase <= '0;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_out_val  <= 1'b0;
      r_oe       <= 1'b0;
      r_blink_en <= 1'b0;
      r_done_ie  <= 1'b0;
      r_done     <= 1'b0;
      r_period   <= '0;
      r_count    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_out_val  <= wb_dat_i[0];
        r_oe       <= wb_dat_i[1];
        r_blink_en <= wb_dat_i[2];
        r_done_ie  <= wb_dat_i[3];
      end
      if (w_set_done) r_blink_en <= 1'b0;
      if (w_wr_period)
        r_period <= (r_period & ~w_lane_mask[PERIOD_W-1:0]) |
                    (wb_dat_i[PERIOD_W-1:0] & w_lane_mask[PERIOD_W-1:0]);
      if (w_wr_count)
        r_count <= (r_count & ~w_lane_mask[COUNT_W-1:0]) |
                   (wb_dat_i[COUNT_W-1:0] & w_lane_mask[COUNT_W-1:0]);
      if (w_set_done)                    r_done <= 1'b1;
      else if (w_wr_status & wb_dat_i[2]) r_done <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i[3:2])
      2'd0: w_rdata[3:0] = {r_done_ie, r_blink_en, r_oe, r_out_val};
      2'd1: w_rdata[PERIOD_W-1:0] = r_period;
      2'd2: w_rdata[COUNT_W-1:0] = r_count;
      default: begin
        w_rdata[0]            = w_sync_in;
        w_rdata[1]            = w_busy;
        w_rdata[2]            = r_done;
        w_rdata[8 +: COUNT_W] = r_remaining;
      end
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_sync <= '0;
    end else begin
      r_ack  <= w_acc;
      r_dat  <= w_acc ? w_rdata : 32'h0;
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in_pad};
    end
  end

endmodule
